gerenciador_de_ataque_fsm: RTL and testbench

- Parametrised, fully synchronous attack manager for the naval-battle game.
- Generalises grid size and life count.
- Adds an explicit game FSM with a one-cycle evaluation stage, repeated/invalid-shot detection, a shot counter, and win/defeat flags.
- Sits between the coordinate-entry front end and the LED-matrix/status drivers; the map comes from the map-storage block.

---
 rtl/gerenciador_de_ataque_fsm.sv | 221 ++++++++++++++++++++++
 tb/tb_gerenciador_de_ataque_fsm.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/gerenciador_de_ataque_fsm.sv
// -----------------------------------------------------------------------------
// gerenciador_de_ataque_fsm
//
// Attack manager for the naval-battle game. It takes a target coordinate from
// the entry front end, evaluates it against the ship map in a one-cycle
// evaluation state, and keeps track of the hit matrix, every cell fired on,
// remaining lives and the count of valid shots. It also raises the win and
// defeat flags.
//
// Ports:
//   clock        in   system clock, all state on the rising edge
//   reset        in   asynchronous active-high reset
//   enable       in   game active; low returns the game to IDLE
//   confirmar    in   fire request (level); fires once per rising edge
//   coordColuna  in   target column   [LW-1:0]
//   coordLinha   in   target row      [LW-1:0]
//   mapa         in   ship map, bit index = col*LINHAS+row, 1 = ship
//   matriz       out  ship cells hit so far (same indexing as mapa)
//   tentado      out  every cell already fired on
//   LED_R        out  last shot missed
//   LED_G        out  last shot hit
//   LED_B        out  last shot repeated or out of range
//   vida         out  remaining lives   [VW-1:0]
//   tiros        out  valid shot count, saturating   [TW-1:0]
//   fim_vitoria  out  every ship cell has been hit
//   fim_derrota  out  no lives left
// -----------------------------------------------------------------------------
module gerenciador_de_ataque_fsm #(
    parameter int LINHAS  = 7,
    parameter int COLUNAS = 5,
    parameter int VIDAS   = 3,
    parameter int LW      = 3,
    parameter int VW      = 3,
    parameter int TW      = 6
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        enable,
    input  logic                        confirmar,
    input  logic [LW-1:0]               coordColuna,
    input  logic [LW-1:0]               coordLinha,
    input  logic [LINHAS*COLUNAS-1:0]   mapa,
    output logic [LINHAS*COLUNAS-1:0]   matriz,
    output logic [LINHAS*COLUNAS-1:0]   tentado,
    output logic                        LED_R,
    output logic                        LED_G,
    output logic                        LED_B,
    output logic [VW-1:0]               vida,
    output logic [TW-1:0]               tiros,
    output logic                        fim_vitoria,
    output logic                        fim_derrota
);

    localparam int N = LINHAS * COLUNAS;
    localparam logic [N-1:0] ONE_CELL = {{(N-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        IDLE,
        JOGANDO,
        AVALIA,
        VITORIA,
        DERROTA
    } estado_t;

    estado_t         r_estado, w_estado_next;
    logic            r_conf_q;
    logic [LW-1:0]   r_col, r_lin, w_col_next, w_lin_next;
    logic [N-1:0]    r_matriz, r_tentado, w_matriz_next, w_tentado_next;
    logic            r_led_r, r_led_g, r_led_b;
    logic            w_led_r_next, w_led_g_next, w_led_b_next;
    logic [VW-1:0]   r_vida, w_vida_next;
    logic [TW-1:0]   r_tiros, w_tiros_next, w_tiros_inc;
    logic            r_fim_v, r_fim_d, w_fim_v_next, w_fim_d_next;

    logic            w_disparo;
    int              w_idx;
    logic [N-1:0]    w_mask;
    logic            w_fora, w_repetido, w_acerto;

    // Rising edge of the fire request: holding confirmar high fires only once.
    assign w_disparo = confirmar & ~r_conf_q;

    // Target cell decode from the captured coordinate. When out of range the
    // mask may be garbage, but it is never used in that case.
    assign w_idx      = int'(r_col) * LINHAS + int'(r_lin);
    assign w_mask     = ONE_CELL << w_idx;
    assign w_fora     = (int'(r_col) >= COLUNAS) || (int'(r_lin) >= LINHAS);
    assign w_repetido = |(r_tentado & w_mask);
    assign w_acerto   = |(mapa & w_mask);

    assign w_tiros_inc = (r_tiros == '1) ? r_tiros : r_tiros + TW'(1);

    // NOTE: every signal gets its hold value first so no path leaves a
    // combinational output unassigned (which would infer a latch).
    always_comb begin
        w_estado_next  = r_estado;
        w_col_next     = r_col;
        w_lin_next     = r_lin;
        w_matriz_next  = r_matriz;
        w_tentado_next = r_tentado;
        w_led_r_next   = r_led_r;
        w_led_g_next   = r_led_g;
        w_led_b_next   = r_led_b;
        w_vida_next    = r_vida;
        w_tiros_next   = r_tiros;
        w_fim_v_next   = r_fim_v;
        w_fim_d_next   = r_fim_d;

        if (!enable || r_estado == IDLE) begin
            // IDLE holds the reset values; dropping enable anywhere (even
            // mid-evaluation) discards everything, including a pending shot.
            w_estado_next  = enable ? JOGANDO : IDLE;
            w_matriz_next  = '0;
            w_tentado_next = '0;
            w_led_r_next   = 1'b0;
            w_led_g_next   = 1'b0;
            w_led_b_next   = 1'b0;
            w_vida_next    = VW'(VIDAS);
            w_tiros_next   = '0;
            w_fim_v_next   = 1'b0;
            w_fim_d_next   = 1'b0;
        end else begin
            case (r_estado)
                JOGANDO: begin
                    if (w_disparo) begin
                        w_col_next    = coordColuna;
                        w_lin_next    = coordLinha;
                        w_estado_next = AVALIA;
                    end
                end

                AVALIA: begin
                    w_estado_next = JOGANDO;
                    w_led_r_next  = 1'b0;
                    w_led_g_next  = 1'b0;
                    w_led_b_next  = 1'b0;
                    if (w_fora || w_repetido) begin
                        w_led_b_next = 1'b1;
                    end else if (w_acerto) begin
                        w_matriz_next  = r_matriz | w_mask;
                        w_tentado_next = r_tentado | w_mask;
                        w_led_g_next   = 1'b1;
                        w_tiros_next   = w_tiros_inc;
                        // Win check only follows a hit, so an empty map never wins.
                        if ((w_matriz_next & mapa) == mapa) begin
                            w_estado_next = VITORIA;
                            w_fim_v_next  = 1'b1;
                        end
                    end else begin
                        w_tentado_next = r_tentado | w_mask;
                        w_led_r_next   = 1'b1;
                        w_tiros_next   = w_tiros_inc;
                        if (r_vida != '0) begin
                            w_vida_next = r_vida - VW'(1);
                        end
                        if (w_vida_next == '0) begin
                            w_estado_next = DERROTA;
                            w_fim_d_next  = 1'b1;
                        end
                    end
                end

                // Terminal states: everything frozen until enable drops.
                VITORIA, DERROTA: ;

                default: w_estado_next = IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block ordering.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_estado <= IDLE;
        end else begin
            r_estado <= w_estado_next;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_conf_q  <= 1'b0;
            r_col     <= '0;
            r_lin     <= '0;
            r_matriz  <= '0;
            r_tentado <= '0;
            r_led_r   <= 1'b0;
            r_led_g   <= 1'b0;
            r_led_b   <= 1'b0;
            r_vida    <= VW'(VIDAS);
            r_tiros   <= '0;
            r_fim_v   <= 1'b0;
            r_fim_d   <= 1'b0;
        end else begin
            r_conf_q  <= confirmar;
            r_col     <= w_col_next;
            r_lin     <= w_lin_next;
            r_matriz  <= w_matriz_next;
            r_tentado <= w_tentado_next;
            r_led_r   <= w_led_r_next;
            r_led_g   <= w_led_g_next;
            r_led_b   <= w_led_b_next;
            r_vida    <= w_vida_next;
            r_tiros   <= w_tiros_next;
            r_fim_v   <= w_fim_v_next;
            r_fim_d   <= w_fim_d_next;
        end
    end

    assign matriz      = r_matriz;
    assign tentado     = r_tentado;
    assign LED_R       = r_led_r;
    assign LED_G       = r_led_g;
    assign LED_B       = r_led_b;
    assign vida        = r_vida;
    assign tiros       = r_tiros;
    assign fim_vitoria = r_fim_v;
    assign fim_derrota = r_fim_d;

endmodule

// File: tb/tb_gerenciador_de_ataque_fsm.sv
// -----------------------------------------------------------------------------
// tb_gerenciador_de_ataque_fsm
//
// Directed bench for gerenciador_de_ataque_fsm with default parameters.
// Stimulus pushes hand-computed expected outputs, tagged with the cycle at
// which they must be visible, into a scoreboard queue; a monitor process pops
// and compares them one time unit after each rising edge.
// Ship cells (col,row): (0,0),(0,4),(0,5),(0,6),(1,5) -> bits 0,4,5,6,12.
// -----------------------------------------------------------------------------
module tb_gerenciador_de_ataque_fsm;

    localparam logic [2:0] RGB_NONE = 3'b000;
    localparam logic [2:0] RGB_R    = 3'b100;
    localparam logic [2:0] RGB_G    = 3'b010;
    localparam logic [2:0] RGB_B    = 3'b001;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        confirmar;
    logic [2:0]  coordColuna;
    logic [2:0]  coordLinha;
    logic [34:0] mapa;
    logic [34:0] matriz;
    logic [34:0] tentado;
    logic        LED_R, LED_G, LED_B;
    logic [2:0]  vida;
    logic [5:0]  tiros;
    logic        fim_vitoria, fim_derrota;

    gerenciador_de_ataque_fsm dut (
        .clock       (clk),
        .reset       (reset),
        .enable      (enable),
        .confirmar   (confirmar),
        .coordColuna (coordColuna),
        .coordLinha  (coordLinha),
        .mapa        (mapa),
        .matriz      (matriz),
        .tentado     (tentado),
        .LED_R       (LED_R),
        .LED_G       (LED_G),
        .LED_B       (LED_B),
        .vida        (vida),
        .tiros       (tiros),
        .fim_vitoria (fim_vitoria),
        .fim_derrota (fim_derrota)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        string       name;
        logic [34:0] matriz;
        logic [34:0] tentado;
        logic [2:0]  rgb;
        logic [2:0]  vida;
        logic [5:0]  tiros;
        logic        fv;
        logic        fd;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t mk(input string nm, input logic [34:0] m, input logic [34:0] t,
                                input logic [2:0] rgb, input logic [2:0] v, input logic [5:0] ti,
                                input logic fv, input logic fd);
        exp_t e;
        e.due = 0; e.name = nm; e.matriz = m; e.tentado = t; e.rgb = rgb;
        e.vida = v; e.tiros = ti; e.fv = fv; e.fd = fd;
        return e;
    endfunction

    function automatic exp_t rst_vals(input string nm);
        return mk(nm, 35'h0, 35'h0, RGB_NONE, 3'd3, 6'd0, 1'b0, 1'b0);
    endfunction

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, got, exp);
        end
    endtask

    task automatic compare_all(input exp_t e);
        check({e.name, ".matriz"},  64'(matriz),  64'(e.matriz));
        check({e.name, ".tentado"}, 64'(tentado), 64'(e.tentado));
        check({e.name, ".rgb"},     64'({LED_R, LED_G, LED_B}), 64'(e.rgb));
        check({e.name, ".vida"},    64'(vida),    64'(e.vida));
        check({e.name, ".tiros"},   64'(tiros),   64'(e.tiros));
        check({e.name, ".fim_v"},   64'(fim_vitoria), 64'(e.fv));
        check({e.name, ".fim_d"},   64'(fim_derrota), 64'(e.fd));
    endtask

    // Monitor: compares every entry whose due cycle has arrived.
    always @(posedge clk) begin
        #1;
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            compare_all(sb.pop_front());
        end
    end

    // Expect the given state right after the next rising edge.
    task automatic expect_next(input exp_t e);
        @(negedge clk);
        e.due = cyc + 1;
        sb.push_back(e);
    endtask

    // Single fire pulse; result is visible after the second rising edge.
    task automatic fire(input logic [2:0] col, input logic [2:0] row, input exp_t e);
        @(negedge clk);
        coordColuna = col;
        coordLinha  = row;
        confirmar   = 1'b1;
        e.due = cyc + 2;
        sb.push_back(e);
        @(negedge clk);
        confirmar = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // Drop enable for one cycle (expecting a full clear), then re-enable.
    task automatic restart(input string nm);
        @(negedge clk);
        enable = 1'b0;
        expect_next(rst_vals(nm));
        enable = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        exp_t e;
        reset       = 1'b1;
        enable      = 1'b1;
        confirmar   = 1'b0;
        coordColuna = '0;
        coordLinha  = '0;
        mapa        = 35'h0000_1071;

        repeat (2) @(posedge clk);
        #1;
        compare_all(rst_vals("reset"));
        @(negedge clk);
        reset = 1'b0;

        // Basic hit / miss / repeat / out of range.
        fire(3'd0, 3'd0, mk("hit_00",   35'h1, 35'h1,     RGB_G, 3'd3, 6'd1, 1'b0, 1'b0));
        fire(3'd2, 3'd3, mk("miss_23",  35'h1, 35'h20001, RGB_R, 3'd2, 6'd2, 1'b0, 1'b0));
        fire(3'd2, 3'd3, mk("rep_23",   35'h1, 35'h20001, RGB_B, 3'd2, 6'd2, 1'b0, 1'b0));
        fire(3'd5, 3'd0, mk("oor_col",  35'h1, 35'h20001, RGB_B, 3'd2, 6'd2, 1'b0, 1'b0));
        fire(3'd0, 3'd7, mk("oor_row",  35'h1, 35'h20001, RGB_B, 3'd2, 6'd2, 1'b0, 1'b0));

        // Held confirmar: exactly one evaluation.
        e = mk("hold_first", 35'h1, 35'h20081, RGB_R, 3'd1, 6'd3, 1'b0, 1'b0);
        @(negedge clk);
        coordColuna = 3'd1;
        coordLinha  = 3'd0;
        confirmar   = 1'b1;
        e.due = cyc + 2;
        sb.push_back(e);
        repeat (10) @(negedge clk);
        confirmar = 1'b0;
        e.name = "hold_after";
        e.due  = cyc + 1;
        sb.push_back(e);
        repeat (2) @(negedge clk);

        // Defeat from a fresh game, then ignored shots, then clear.
        restart("clear_1");
        fire(3'd1, 3'd0, mk("def_m1", 35'h0, 35'h080, RGB_R, 3'd2, 6'd1, 1'b0, 1'b0));
        fire(3'd1, 3'd1, mk("def_m2", 35'h0, 35'h180, RGB_R, 3'd1, 6'd2, 1'b0, 1'b0));
        fire(3'd1, 3'd2, mk("def_m3", 35'h0, 35'h380, RGB_R, 3'd0, 6'd3, 1'b0, 1'b1));
        fire(3'd0, 3'd0, mk("def_ign", 35'h0, 35'h380, RGB_R, 3'd0, 6'd3, 1'b0, 1'b1));
        restart("clear_2");

        // Victory with one miss in between.
        fire(3'd0, 3'd0, mk("win_h1", 35'h0001, 35'h0000001, RGB_G, 3'd3, 6'd1, 1'b0, 1'b0));
        fire(3'd0, 3'd4, mk("win_h2", 35'h0011, 35'h0000011, RGB_G, 3'd3, 6'd2, 1'b0, 1'b0));
        fire(3'd3, 3'd3, mk("win_m",  35'h0011, 35'h1000011, RGB_R, 3'd2, 6'd3, 1'b0, 1'b0));
        fire(3'd0, 3'd5, mk("win_h3", 35'h0031, 35'h1000031, RGB_G, 3'd2, 6'd4, 1'b0, 1'b0));
        fire(3'd0, 3'd6, mk("win_h4", 35'h0071, 35'h1000071, RGB_G, 3'd2, 6'd5, 1'b0, 1'b0));
        fire(3'd1, 3'd5, mk("win_h5", 35'h1071, 35'h1001071, RGB_G, 3'd2, 6'd6, 1'b1, 1'b0));
        fire(3'd2, 3'd2, mk("win_ign", 35'h1071, 35'h1001071, RGB_G, 3'd2, 6'd6, 1'b1, 1'b0));

        // Asynchronous reset in the middle of an evaluation.
        restart("clear_3");
        fire(3'd0, 3'd0, mk("pre_rst", 35'h1, 35'h1, RGB_G, 3'd3, 6'd1, 1'b0, 1'b0));
        @(negedge clk);
        coordColuna = 3'd0;
        coordLinha  = 3'd4;
        confirmar   = 1'b1;
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        compare_all(rst_vals("async_rst"));
        @(negedge clk);
        confirmar = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        e = rst_vals("post_rst");
        e.due = cyc + 2;
        sb.push_back(e);
        repeat (3) @(negedge clk);
        fire(3'd0, 3'd4, mk("after_rst", 35'h10, 35'h10, RGB_G, 3'd3, 6'd1, 1'b0, 1'b0));

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            n_cmp++;
            n_err++;
            $display("FAIL %s: got no comparison, expected one by cycle %0d", e.name, e.due);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
